// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Purpose : Shared definitions for the push-button debouncer.
//           - state_t       : 2-bit FSM state encoding
//           - PRESS_COUNT_W : width of the accepted-press counter
//           - level_of()    : debounced level implied by a state
//
// Ports   : none (package)
// -----------------------------------------------------------------------------
package debounce_pkg;

  // IDLE      : debounced level is low and stable
  // WAIT_HIGH : low level, candidate high level being qualified
  // HIGH      : debounced level is high and stable
  // WAIT_LOW  : high level, candidate low level being qualified
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam int PRESS_COUNT_W = 8;

  // The debounced level only changes once a wait state has fully qualified,
  // so both wait states report the level of the stable state they came from.
  function automatic logic level_of(input state_t s);
    return (s == ST_HIGH) || (s == ST_WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//
// Purpose : STAGES-deep shift register that samples an asynchronous level into
//           the clk domain. With STAGES >= 2 it acts as a metastability
//           synchronizer; with STAGES = 1 it is a plain sample register.
//
// Parameters:
//   STAGES : number of flops in the chain (>= 1)
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : sampled output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_stage;

  // Written as a loop so the same code covers STAGES = 1, where a
  // concatenation-based shift would need an empty slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Purpose : Debounces a raw push-button level. A level change is accepted only
//           after the sampled input has sat at the new level for
//           DEBOUNCE_CYCLES consecutive samples past the first differing one.
//           Each accepted press (low->high) emits a one-cycle T pulse for a
//           downstream T flip-flop and bumps a wrapping press counter.
//           Releases change the level but never pulse T.
//
// Build option:
//   BUTTON_DEBOUNCER_SYNC2_EN defined   : two-flop input synchronizer (S = 2)
//   BUTTON_DEBOUNCER_SYNC2_EN undefined : single sample register (S = 1)
//   With btn held high, T rises after the (S + DEBOUNCE_CYCLES + 1)th clock
//   edge following the btn rise.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable-sample count N, legal range 2 .. 2**20
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   btn          : raw, asynchronous, bouncy button level
//   T            : registered single-cycle toggle request on each accepted press
//   level        : registered debounced button level
//   press_count  : accepted presses modulo 256
//   o_dbg_state  : current FSM state (debug observation only)
//
// All outputs come straight from flops; there is no combinational path from
// btn to any output.
// -----------------------------------------------------------------------------
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn,
  output logic                     T,
  output logic                     level,
  output logic [PRESS_COUNT_W-1:0] press_count,
  output logic [1:0]               o_dbg_state
);

`ifdef BUTTON_DEBOUNCER_SYNC2_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input sampling
  // ---------------------------------------------------------------------------
  logic w_btn_s;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (w_btn_s)
  );

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_t;
  logic                     r_level;
  logic [PRESS_COUNT_W-1:0] r_press_count;

  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     w_t_nxt;
  logic                     w_level_nxt;
  logic [PRESS_COUNT_W-1:0] w_press_nxt;

  // Next-state logic. Entering a wait state counts as the first qualifying
  // sample (cnt = 0); the change is accepted on the sample where cnt already
  // equals N-1, i.e. N+1 consecutive samples at the candidate level in total.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_t_nxt     = 1'b0;
    w_press_nxt = r_press_count;

    case (r_state)
      ST_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = ST_WAIT_HIGH;
          w_cnt_nxt   = '0;
        end
      end

      ST_WAIT_HIGH: begin
        if (!w_btn_s) begin
          // Glitch: fall back without touching any output.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
          w_t_nxt     = 1'b1;
          w_press_nxt = r_press_count + PRESS_COUNT_W'(1);
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_HIGH: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_WAIT_LOW;
          w_cnt_nxt   = '0;
        end
      end

      ST_WAIT_LOW: begin
        if (w_btn_s) begin
          // Release glitch: stay pressed.
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          // Accepted release: level drops, no T pulse.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // level is registered alongside the state it describes.
    w_level_nxt = level_of(w_state_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_t           <= 1'b0;
      r_level       <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_t           <= w_t_nxt;
      r_level       <= w_level_nxt;
      r_press_count <= w_press_nxt;
    end
  end

  assign T           = r_t;
  assign level       = r_level;
  assign press_count = r_press_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer (N = 8). The input stage depth S
// follows BUTTON_DEBOUNCER_SYNC2_EN exactly as the design does.
//
// Reference model: btn is delayed by S samples (zeros after reset); the
// debounced level flips once N+1 consecutive delayed samples differ from it,
// and a flip to 1 produces a T pulse and a press count increment.
// Directed tests additionally check absolute pulse timing (S+N+1 edges after
// the rise) through an expected-edge queue.
// -----------------------------------------------------------------------------
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int N = 8;
`ifdef BUTTON_DEBOUNCER_SYNC2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int LAT = S + N + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       T;
  logic       level;
  logic [7:0] press_count;
  logic [1:0] o_dbg_state;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .T           (T),
    .level       (level),
    .press_count (press_count),
    .o_dbg_state (o_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  logic [31:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Reference model (updated on every rising edge)
  // ---------------------------------------------------------------------------
  bit       m_dly[$];
  bit       m_seen;
  logic     m_level = 1'b0;
  logic     m_t     = 1'b0;
  logic [7:0] m_count = 8'd0;
  int       m_run   = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      m_dly.delete();
      for (int i = 0; i < S; i++) m_dly.push_back(1'b0);
      m_level = 1'b0;
      m_t     = 1'b0;
      m_count = 8'd0;
      m_run   = 0;
    end else begin
      m_seen = m_dly.pop_front();
      m_dly.push_back(btn);
      m_t = 1'b0;
      if (m_seen != m_level) begin
        m_run++;
        if (m_run == N + 1) begin
          m_level = m_seen;
          m_run   = 0;
          if (m_seen) begin
            m_t     = 1'b1;
            m_count = m_count + 8'd1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic v);
    btn = v;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'($urandom_range(0, 1)));
      n_checks++;
      if (T !== 1'b0 || level !== 1'b0 || press_count !== 8'd0 || o_dbg_state !== ST_IDLE) begin
        n_errors++;
        $display("FAIL reset_outputs: got T=%b level=%b cnt=%0d state=%0d, need 0 0 0 0",
                 T, level, press_count, o_dbg_state);
      end
    end
    btn = 1'b0;
    rst = 1'b0;
    drive_cycle(1'b0);
    n_checks++;
    if (T !== 1'b0 || level !== 1'b0 || press_count !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_release: got T=%b level=%b cnt=%0d, need 0 0 0", T, level, press_count);
    end
  endtask

  task automatic test_clean_press();
    int rise;
    int fall;
    int pulses = 0;
    rise = edge_cnt;
    exp_q.push_back(32'(rise + LAT));
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1);
      n_checks++;
      if (T !== m_t || level !== m_level || press_count !== m_count) begin
        n_errors++;
        $display("FAIL clean_model: edge %0d got T=%b level=%b cnt=%0d, need %b %b %0d",
                 edge_cnt, T, level, press_count, m_t, m_level, m_count);
      end
      if (T === 1'b1) begin
        pulses++;
        n_checks++;
        if (exp_q.size() == 0 || 32'(edge_cnt) != exp_q[0]) begin
          n_errors++;
          $display("FAIL clean_latency: pulse at edge %0d, need edge %0d", edge_cnt, rise + LAT);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (pulses != 1 || level !== 1'b1 || press_count !== 8'd1) begin
      n_errors++;
      $display("FAIL clean_result: got pulses=%0d level=%b cnt=%0d, need 1 1 1", pulses, level, press_count);
    end
    // Release: level falls S+N+1 edges after btn falls, T stays low.
    fall = edge_cnt;
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0);
      n_checks++;
      if (T !== 1'b0 || level !== ((edge_cnt - fall) < LAT)) begin
        n_errors++;
        $display("FAIL release_level: edge %0d got T=%b level=%b, need 0 %b",
                 edge_cnt, T, level, (edge_cnt - fall) < LAT);
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] cnt0;
    cnt0 = press_count;
    for (int i = 0; i < 30; i++) begin
      drive_cycle(i < 5);
      n_checks++;
      if (T !== 1'b0 || level !== 1'b0 || press_count !== m_count || press_count !== cnt0) begin
        n_errors++;
        $display("FAIL glitch: edge %0d got T=%b level=%b cnt=%0d, need 0 0 %0d",
                 edge_cnt, T, level, press_count, cnt0);
      end
    end
  endtask

  task automatic test_bounce();
    int rise = 0;
    int fall = 0;
    int pulses = 0;
    logic [7:0] cnt0;
    logic v;
    cnt0 = press_count;
    // Press bounce: 1,1,0,0,1,1,0,0, then the final rise at index 8 holds.
    for (int i = 0; i < 30; i++) begin
      v = (i >= 8) ? 1'b1 : ((i % 4) < 2);
      if (i == 8) begin
        rise = edge_cnt;
        exp_q.push_back(32'(rise + LAT));
      end
      drive_cycle(v);
      n_checks++;
      if (T !== m_t || level !== m_level) begin
        n_errors++;
        $display("FAIL bounce_model: edge %0d got T=%b level=%b, need %b %b", edge_cnt, T, level, m_t, m_level);
      end
      if (T === 1'b1) begin
        pulses++;
        n_checks++;
        if (exp_q.size() == 0 || 32'(edge_cnt) != exp_q[0]) begin
          n_errors++;
          $display("FAIL bounce_latency: pulse at edge %0d, need edge %0d", edge_cnt, rise + LAT);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (pulses != 1 || press_count !== cnt0 + 8'd1) begin
      n_errors++;
      $display("FAIL bounce_press: got pulses=%0d cnt=%0d, need 1 %0d", pulses, press_count, cnt0 + 8'd1);
    end
    // Release bounce: 0,0,1,1,0,0,1,1, then the final fall at index 8 holds.
    for (int i = 0; i < 30; i++) begin
      v = (i >= 8) ? 1'b0 : ((i % 4) >= 2);
      if (i == 8) fall = edge_cnt;
      drive_cycle(v);
      n_checks++;
      if (T !== 1'b0 || level !== ((i < 8) || ((edge_cnt - fall) < LAT))) begin
        n_errors++;
        $display("FAIL bounce_release: edge %0d got T=%b level=%b, need 0 %b",
                 edge_cnt, T, level, (i < 8) || ((edge_cnt - fall) < LAT));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int rel;
    int pulses = 0;
    // Starting from stable low: after S+5 high cycles the counter holds 4.
    for (int i = 0; i < S + 5; i++) begin
      drive_cycle(1'b1);
      n_checks++;
      if (T !== 1'b0 || level !== 1'b0) begin
        n_errors++;
        $display("FAIL midwait_pre: edge %0d got T=%b level=%b, need 0 0", edge_cnt, T, level);
      end
    end
    rst = 1'b1;
    drive_cycle(1'b1);
    n_checks++;
    if (T !== 1'b0 || level !== 1'b0 || press_count !== 8'd0 || o_dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL midwait_reset: got T=%b level=%b cnt=%0d state=%0d, need 0 0 0 0",
               T, level, press_count, o_dbg_state);
    end
    rst = 1'b0;
    rel = edge_cnt;
    exp_q.push_back(32'(rel + LAT));
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1);
      if (T === 1'b1) begin
        pulses++;
        n_checks++;
        if (exp_q.size() == 0 || 32'(edge_cnt) != exp_q[0]) begin
          n_errors++;
          $display("FAIL midwait_latency: pulse at edge %0d, need edge %0d", edge_cnt, rel + LAT);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (pulses != 1 || level !== 1'b1 || press_count !== 8'd1) begin
      n_errors++;
      $display("FAIL midwait_result: got pulses=%0d level=%b cnt=%0d, need 1 1 1", pulses, level, press_count);
    end
    for (int i = 0; i < LAT + 2; i++) drive_cycle(1'b0);
  endtask

  task automatic test_random();
    logic v = 1'b0;
    int   len;
    int   cyc = 0;
    while (cyc < 2000) begin
      v   = ($urandom_range(0, 3) == 0) ? v : ~v;
      len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) begin
        drive_cycle(v);
        cyc++;
        n_checks++;
        if (T !== m_t || level !== m_level || press_count !== m_count) begin
          n_errors++;
          $display("FAIL random: edge %0d got T=%b level=%b cnt=%0d, need %b %b %0d",
                   edge_cnt, T, level, press_count, m_t, m_level, m_count);
        end
      end
    end
    for (int i = 0; i < LAT + 2; i++) drive_cycle(1'b0);
  endtask

  task automatic test_wrap();
    int pulses = 0;
    rst = 1'b1;
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    rst = 1'b0;
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < LAT + 2; i++) begin
        drive_cycle(1'b1);
        if (T === 1'b1) pulses++;
      end
      n_checks++;
      if (press_count !== 8'(p + 1)) begin
        n_errors++;
        $display("FAIL wrap_count: after press %0d got %0d, need %0d", p + 1, press_count, 8'(p + 1));
      end
      for (int i = 0; i < LAT + 2; i++) begin
        drive_cycle(1'b0);
        if (T === 1'b1) pulses++;
      end
    end
    n_checks++;
    if (pulses != 256 || press_count !== 8'd0 || level !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_result: got pulses=%0d cnt=%0d level=%b, need 256 0 0", pulses, press_count, level);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    rst = 1'b1;
    drive_cycle(1'b0);
    rst = 1'b0;
    drive_cycle(1'b0);
    test_reset_mid_wait();
    test_random();
    test_wrap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pulse_queue: %0d expected pulses never seen, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 8, giving the stable-sample count N required to accept a level change (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1 bit, sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 The block SHALL have port btn, input, 1 bit, raw asynchronous push-button level (bouncy).
REQ-005 The block SHALL have port T, output, 1 bit, single-cycle toggle-request pulse driving the downstream T flip-flop T input.
REQ-006 The block SHALL have port level, output, 1 bit, debounced button level.
REQ-007 The block SHALL have port press_count, output, 8 bits, accepted presses modulo 256.

Function
REQ-008 The block SHALL sample btn through S input register stages to form btn_s (S per REQ-020/021).
REQ-009 The FSM SHALL have states IDLE (stable low), WAIT_HIGH, HIGH (stable high) and WAIT_LOW, with counter cnt of width clog2(N).
REQ-010 In IDLE with btn_s=1, the FSM SHALL move to WAIT_HIGH with cnt=0; in HIGH with btn_s=0, it SHALL move to WAIT_LOW with cnt=0.
REQ-011 In WAIT_HIGH/WAIT_LOW with btn_s at the candidate level and cnt<N-1, the block SHALL increment cnt.
REQ-012 In WAIT_HIGH/WAIT_LOW with btn_s at the candidate level and cnt=N-1, the FSM SHALL move to HIGH/LOW-stable (HIGH resp. IDLE) and clear cnt.
REQ-013 In WAIT_HIGH/WAIT_LOW with btn_s reverting to the old level, the FSM SHALL return to the previous stable state, clear cnt, and produce no output change (glitch rejected).
REQ-014 On the WAIT_HIGH->HIGH transition edge, T SHALL be registered to 1 for exactly one clock cycle and press_count SHALL increment by 1.
REQ-015 T SHALL be 0 in every other cycle; release (WAIT_LOW->IDLE) SHALL NOT pulse T.
REQ-016 Latency: with btn held high continuously, T SHALL assert in the cycle after the (S+N+1)th rising edge following btn rising.
REQ-017 level SHALL be 1 in HIGH and WAIT_LOW, and 0 in IDLE and WAIT_HIGH, registered together with the state.
REQ-018 press_count SHALL wrap 255->0 with no saturation or flag.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set the synchronizer flops to 0, state to IDLE, cnt to 0, T to 0, level to 0 and press_count to 0; rst SHALL override any in-progress wait, and a btn held high across reset release SHALL be treated as a new press with full REQ-016 latency.

Configuration
REQ-020 With macro BUTTON_DEBOUNCER_SYNC2_EN defined, the block SHALL use S=2 (two-flop metastability synchronizer).
REQ-021 With BUTTON_DEBOUNCER_SYNC2_EN undefined, the block SHALL use S=1 (single sample register) and all latencies SHALL shrink by one cycle; FSM behaviour SHALL otherwise be identical.

Structure
REQ-022 Shared package debounce_pkg SHALL hold the 2-bit state encodings (IDLE=0, WAIT_HIGH=1, HIGH=2, WAIT_LOW=3) and the press_count width constant (8).
REQ-023 The synchronizer SHALL be a sub-module sync_ff (parameter STAGES, ports clk, rst, d, q) instantiated once.
REQ-024 The block SHALL contain no combinational path from btn to any output.

Verification (N=8, BUTTON_DEBOUNCER_SYNC2_EN defined unless stated)
REQ-025 Clean press: btn 0->1 held 20 cycles -> one T pulse exactly 11 edges after the rise, level=1, press_count=1.
REQ-026 Glitch: btn high for 5 cycles then low -> T never asserts, level stays 0, press_count=0.
REQ-027 Bounce: btn toggles every 2 cycles for 10 cycles, then stays high -> exactly one T pulse, timed from the final rise; release bounce then low -> no T pulse, level returns to 0 after N+1 stable samples.
REQ-028 Reset mid-wait: btn high, rst asserted at cnt=4 for 1 cycle, btn still high -> T asserts 11 edges after rst deasserts; all outputs 0 during reset.
REQ-029 Wrap: 256 clean presses -> 256 T pulses, press_count back to 0.
REQ-030 Macro undefined: repeat REQ-025 -> T asserts 10 edges after the rise.
